// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared widths, entry record and helpers for the reservation station
package rs_pkg;

    localparam int RS_TAG_W  = 6;
    localparam int RS_ROB_W  = 6;
    localparam int RS_DATA_W = 32;
    localparam int RS_OP_W   = 4;
    localparam int RS_MAX_FU = 4;
    localparam int RS_FU_W   = 2;

    typedef logic [RS_FU_W-1:0] fu_idx_t;

    typedef struct packed {
        logic                 valid;
        logic                 is_ls;
        logic                 alusrc;
        logic [RS_OP_W-1:0]   op;
        logic [RS_TAG_W-1:0]  rd;
        logic [RS_TAG_W-1:0]  rs1_tag;
        logic [RS_DATA_W-1:0] rs1_val;
        logic                 rs1_rdy;
        logic [RS_TAG_W-1:0]  rs2_tag;
        logic [RS_DATA_W-1:0] rs2_val;
        logic                 rs2_rdy;
        logic [RS_DATA_W-1:0] imm;
        fu_idx_t              fu;
        logic [RS_ROB_W-1:0]  rob;
    } rs_entry_t;

    function automatic logic [2:0] popcount_fu(input logic [RS_MAX_FU-1:0] v);
        popcount_fu = '0;
        for (int i = 0; i < RS_MAX_FU; i++) begin
            popcount_fu = popcount_fu + 3'(v[i]);
        end
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - picks the oldest candidate from an age matrix (older[i][j]: j is older than i)
module rs_age_select
    import rs_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]            cand,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            grant,
    output logic                        found
);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = cand[i] & ~(|(cand & older[i]));
        end
        found = |cand;
    end

endmodule

// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - reservation station: dispatch with wakeup bypass, per-FU oldest-ready issue, flush
module rs_issue_queue
    import rs_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int NUM_FU   = 3,
    parameter int NUM_WAKE = 4,
    parameter int TAG_W    = RS_TAG_W,
    parameter int ROB_W    = RS_ROB_W,
    parameter int DATA_W   = RS_DATA_W,
    parameter int OP_W     = RS_OP_W,
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OP_W-1:0]            disp_op,
    input  logic                       disp_is_ls,
    input  logic                       disp_alusrc,
    input  logic [TAG_W-1:0]           disp_rd_tag,
    input  logic [ROB_W-1:0]           disp_rob,
    input  logic [DATA_W-1:0]          disp_imm,
    input  logic [TAG_W-1:0]           disp_rs1_tag,
    input  logic [TAG_W-1:0]           disp_rs2_tag,
    input  logic                       disp_rs1_rdy,
    input  logic                       disp_rs2_rdy,
    input  logic [DATA_W-1:0]          disp_rs1_val,
    input  logic [DATA_W-1:0]          disp_rs2_val,
    input  logic [NUM_FU-1:0]          fu_ready,
    input  logic [NUM_WAKE-1:0]        wk_valid,
    input  logic [NUM_WAKE*TAG_W-1:0]  wk_tag,
    input  logic [NUM_WAKE*DATA_W-1:0] wk_val,
    output logic [NUM_FU-1:0]          iss_valid,
    output logic [NUM_FU*OP_W-1:0]     iss_op,
    output logic [NUM_FU-1:0]          iss_is_ls,
    output logic [NUM_FU-1:0]          iss_alusrc,
    output logic [NUM_FU*TAG_W-1:0]    iss_rd_tag,
    output logic [NUM_FU*ROB_W-1:0]    iss_rob,
    output logic [NUM_FU*DATA_W-1:0]   iss_rs1_val,
    output logic [NUM_FU*DATA_W-1:0]   iss_rs2_val,
    output logic [NUM_FU*DATA_W-1:0]   iss_imm,
    output logic [CNT_W-1:0]           count,
    output logic                       empty
);

    rs_entry_t                        ents      [DEPTH];
    rs_entry_t                        ents_woke [DEPTH];
    rs_entry_t                        new_ent;
    rs_entry_t                        win_ent   [NUM_FU];
    logic [DEPTH-1:0][DEPTH-1:0]      older;
    logic [DEPTH-1:0]                 valid_vec;
    logic [DEPTH-1:0]                 issued;
    logic [NUM_FU-1:0][DEPTH-1:0]     cand;
    logic [NUM_FU-1:0][DEPTH-1:0]     grant;
    logic [NUM_FU-1:0]                found;
    logic [2:0]                       issued_cnt;
    fu_idx_t                          fu_ptr;
    fu_idx_t                          assign_fu;
    logic [IDX_W-1:0]                 free_idx;
    logic                             free_found;
    logic                             accept;

    assign disp_ready = (count < CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign accept     = disp_valid & disp_ready & ~flush;
    assign issued_cnt = popcount_fu(RS_MAX_FU'(found));

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ents[i].valid;
            if (!ents[i].valid && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Round-robin FU choice starting after the last assigned FU, preferring ready units
    always_comb begin
        logic got;
        got       = 1'b0;
        assign_fu = fu_idx_t'((int'(fu_ptr) + 1) % NUM_FU);
        for (int k = 1; k <= NUM_FU; k++) begin
            if (!got && fu_ready[(int'(fu_ptr) + k) % NUM_FU]) begin
                got       = 1'b1;
                assign_fu = fu_idx_t'((int'(fu_ptr) + k) % NUM_FU);
            end
        end
    end

    always_comb begin
        logic h1, h2;
        h1              = 1'b0;
        h2              = 1'b0;
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.is_ls   = disp_is_ls;
        new_ent.alusrc  = disp_alusrc;
        new_ent.op      = disp_op;
        new_ent.rd      = disp_rd_tag;
        new_ent.rs1_tag = disp_rs1_tag;
        new_ent.rs1_val = disp_rs1_val;
        new_ent.rs1_rdy = disp_rs1_rdy;
        new_ent.rs2_tag = disp_rs2_tag;
        new_ent.rs2_val = disp_rs2_val;
        new_ent.rs2_rdy = disp_rs2_rdy;
        new_ent.imm     = disp_imm;
        new_ent.fu      = assign_fu;
        new_ent.rob     = disp_rob;
        for (int p = 0; p < NUM_WAKE; p++) begin
            if (!disp_rs1_rdy && !h1 && wk_valid[p] && wk_tag[p*TAG_W +: TAG_W] == disp_rs1_tag) begin
                h1              = 1'b1;
                new_ent.rs1_rdy = 1'b1;
                new_ent.rs1_val = wk_val[p*DATA_W +: DATA_W];
            end
            if (!disp_rs2_rdy && !h2 && wk_valid[p] && wk_tag[p*TAG_W +: TAG_W] == disp_rs2_tag) begin
                h2              = 1'b1;
                new_ent.rs2_rdy = 1'b1;
                new_ent.rs2_val = wk_val[p*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        logic h1, h2;
        for (int i = 0; i < DEPTH; i++) begin
            ents_woke[i] = ents[i];
            h1 = 1'b0;
            h2 = 1'b0;
            for (int p = 0; p < NUM_WAKE; p++) begin
                if (ents[i].valid && !ents[i].rs1_rdy && !h1 && wk_valid[p] &&
                    wk_tag[p*TAG_W +: TAG_W] == ents[i].rs1_tag) begin
                    h1                   = 1'b1;
                    ents_woke[i].rs1_rdy = 1'b1;
                    ents_woke[i].rs1_val = wk_val[p*DATA_W +: DATA_W];
                end
                if (ents[i].valid && !ents[i].rs2_rdy && !h2 && wk_valid[p] &&
                    wk_tag[p*TAG_W +: TAG_W] == ents[i].rs2_tag) begin
                    h2                   = 1'b1;
                    ents_woke[i].rs2_rdy = 1'b1;
                    ents_woke[i].rs2_val = wk_val[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                cand[f][i] = ents[i].valid & ents[i].rs1_rdy & ents[i].rs2_rdy &
                             fu_ready[f] & (ents[i].fu == fu_idx_t'(f));
            end
        end
    end

    for (genvar g = 0; g < NUM_FU; g++) begin : g_sel
        rs_age_select #(.DEPTH(DEPTH)) u_sel (
            .cand  (cand[g]),
            .older (older),
            .grant (grant[g]),
            .found (found[g])
        );
    end

    always_comb begin
        issued = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            win_ent[f] = '0;
            issued     = issued | grant[f];
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[f][i]) begin
                    win_ent[f] = ents[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ents[i] <= '0;
            end
            older       <= '0;
            fu_ptr      <= '0;
            count       <= '0;
            iss_valid   <= '0;
            iss_op      <= '0;
            iss_is_ls   <= '0;
            iss_alusrc  <= '0;
            iss_rd_tag  <= '0;
            iss_rob     <= '0;
            iss_rs1_val <= '0;
            iss_rs2_val <= '0;
            iss_imm     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ents[i] <= ents_woke[i];
                if (issued[i]) begin
                    ents[i].valid <= 1'b0;
                end
            end
            // Reallocating a slot clears its stale column so it is younger than everyone
            if (accept) begin
                ents[free_idx] <= new_ent;
                for (int k = 0; k < DEPTH; k++) begin
                    older[k][free_idx] <= 1'b0;
                end
                older[free_idx] <= valid_vec;
                fu_ptr          <= assign_fu;
            end
            count <= count + CNT_W'(accept) - CNT_W'(issued_cnt);
            for (int f = 0; f < NUM_FU; f++) begin
                iss_valid[f] <= found[f];
                if (found[f]) begin
                    iss_op[f*OP_W +: OP_W]          <= win_ent[f].op;
                    iss_is_ls[f]                    <= win_ent[f].is_ls;
                    iss_alusrc[f]                   <= win_ent[f].alusrc;
                    iss_rd_tag[f*TAG_W +: TAG_W]    <= win_ent[f].rd;
                    iss_rob[f*ROB_W +: ROB_W]       <= win_ent[f].rob;
                    iss_rs1_val[f*DATA_W +: DATA_W] <= win_ent[f].rs1_val;
                    iss_rs2_val[f*DATA_W +: DATA_W] <= win_ent[f].rs2_val;
                    iss_imm[f*DATA_W +: DATA_W]     <= win_ent[f].imm;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb/tb_rs_issue_queue.sv - directed self-checking bench for rs_issue_queue
module tb_rs_issue_queue;

    localparam int DEPTH = 16, NUM_FU = 3, NUM_WAKE = 4;
    localparam int TAG_W = 6, ROB_W = 6, DATA_W = 32, OP_W = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                       clk = 1'b0;
    logic                       reset, flush, disp_valid, disp_ready;
    logic [OP_W-1:0]            disp_op;
    logic                       disp_is_ls, disp_alusrc;
    logic [TAG_W-1:0]           disp_rd_tag, disp_rs1_tag, disp_rs2_tag;
    logic [ROB_W-1:0]           disp_rob;
    logic [DATA_W-1:0]          disp_imm, disp_rs1_val, disp_rs2_val;
    logic                       disp_rs1_rdy, disp_rs2_rdy;
    logic [NUM_FU-1:0]          fu_ready;
    logic [NUM_WAKE-1:0]        wk_valid;
    logic [NUM_WAKE*TAG_W-1:0]  wk_tag;
    logic [NUM_WAKE*DATA_W-1:0] wk_val;
    logic [NUM_FU-1:0]          iss_valid, iss_is_ls, iss_alusrc;
    logic [NUM_FU*OP_W-1:0]     iss_op;
    logic [NUM_FU*TAG_W-1:0]    iss_rd_tag;
    logic [NUM_FU*ROB_W-1:0]    iss_rob;
    logic [NUM_FU*DATA_W-1:0]   iss_rs1_val, iss_rs2_val, iss_imm;
    logic [CNT_W-1:0]           count;
    logic                       empty;

    int checks   = 0;
    int failures = 0;

    rs_issue_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_is_ls(disp_is_ls), .disp_alusrc(disp_alusrc), .disp_rd_tag(disp_rd_tag),
        .disp_rob(disp_rob), .disp_imm(disp_imm),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
        .fu_ready(fu_ready), .wk_valid(wk_valid), .wk_tag(wk_tag), .wk_val(wk_val),
        .iss_valid(iss_valid), .iss_op(iss_op), .iss_is_ls(iss_is_ls), .iss_alusrc(iss_alusrc),
        .iss_rd_tag(iss_rd_tag), .iss_rob(iss_rob), .iss_rs1_val(iss_rs1_val),
        .iss_rs2_val(iss_rs2_val), .iss_imm(iss_imm), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [ROB_W-1:0] rob, input logic is_ls,
                        input logic [TAG_W-1:0] t1, input logic r1, input logic [DATA_W-1:0] v1,
                        input logic [TAG_W-1:0] t2, input logic r2, input logic [DATA_W-1:0] v2);
        disp_valid   = 1'b1;
        disp_op      = 4'h3;
        disp_is_ls   = is_ls;
        disp_alusrc  = 1'b0;
        disp_rd_tag  = TAG_W'(rob + 6'd1);
        disp_rob     = rob;
        disp_imm     = 32'h100 + DATA_W'(rob);
        disp_rs1_tag = t1;
        disp_rs1_rdy = r1;
        disp_rs1_val = v1;
        disp_rs2_tag = t2;
        disp_rs2_rdy = r2;
        disp_rs2_val = v2;
    endtask

    task automatic wake(input int p, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        wk_valid[p]                 = 1'b1;
        wk_tag[p*TAG_W +: TAG_W]    = t;
        wk_val[p*DATA_W +: DATA_W]  = v;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        disp(0, 0, 0, 1, 0, 0, 1, 0);
        disp_valid = 1'b0;
        fu_ready = 3'b111; wk_valid = '0; wk_tag = '0; wk_val = '0;
        step(); step();
        chk("rst_count", 64'(count), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_iss_valid", 64'(iss_valid), 0);
        chk("rst_disp_ready", 64'(disp_ready), 1);
        chk("rst_iss_rob", 64'(iss_rob), 0);
        reset = 1'b0;

        // Three ready uops spread across FUs 1, 2, 0
        disp(6'd1, 1, 0, 1, 32'h11, 0, 1, 32'h22); step();
        chk("t1_count_a", 64'(count), 1);
        chk("t1_iss_none", 64'(iss_valid), 0);
        disp(6'd2, 0, 0, 1, 32'h33, 0, 1, 32'h44); step();
        chk("t1_iss_a", 64'(iss_valid), 3'b010);
        chk("t1_rob_a", 64'(iss_rob[1*ROB_W +: ROB_W]), 1);
        chk("t1_rs1_a", 64'(iss_rs1_val[1*DATA_W +: DATA_W]), 32'h11);
        chk("t1_ls_a", 64'(iss_is_ls[1]), 1);
        disp(6'd3, 0, 0, 1, 32'h55, 0, 1, 32'h66); step();
        chk("t1_iss_b", 64'(iss_valid), 3'b100);
        chk("t1_rob_b", 64'(iss_rob[2*ROB_W +: ROB_W]), 2);
        chk("t1_count_b", 64'(count), 1);
        disp_valid = 1'b0; step();
        chk("t1_iss_c", 64'(iss_valid), 3'b001);
        chk("t1_imm_c", 64'(iss_imm[0*DATA_W +: DATA_W]), 32'h103);
        chk("t1_count_c", 64'(count), 0);
        step();
        chk("t1_iss_idle", 64'(iss_valid), 0);
        chk("t1_empty", 64'(empty), 1);

        // Late wakeup on port 2; uop lands on FU1
        disp(6'd4, 0, 6'd5, 0, 32'h0, 0, 1, 32'h77); step();
        disp_valid = 1'b0;
        wake(2, 6'd5, 32'hDEAD); step();
        chk("t2_iss_wait", 64'(iss_valid), 0);
        wk_valid = '0; step();
        chk("t2_iss", 64'(iss_valid), 3'b010);
        chk("t2_rs1", 64'(iss_rs1_val[1*DATA_W +: DATA_W]), 32'hDEAD);
        step();
        chk("t2_hold", 64'(iss_rs1_val[1*DATA_W +: DATA_W]), 32'hDEAD);
        chk("t2_iss_off", 64'(iss_valid), 0);

        // Same-cycle wakeup bypass; lowest matching port wins; uop lands on FU2
        disp(6'd5, 0, 0, 1, 32'h99, 6'd9, 0, 32'h0);
        wake(0, 6'd9, 32'h1234);
        wake(3, 6'd9, 32'h9999);
        step();
        disp_valid = 1'b0; wk_valid = '0;
        chk("t3_count", 64'(count), 1);
        step();
        chk("t3_iss", 64'(iss_valid), 3'b100);
        chk("t3_rs2", 64'(iss_rs2_val[2*DATA_W +: DATA_W]), 32'h1234);

        // Fill with no FU ready: assignment rotates FU0,1,2,... slot k gets FU k%3
        fu_ready = 3'b000;
        for (int k = 0; k < DEPTH; k++) begin
            disp(6'(k), 0, 0, 1, 32'(k), 0, 1, 32'h0);
            step();
        end
        chk("t4_full_count", 64'(count), DEPTH);
        chk("t4_full_ready", 64'(disp_ready), 0);
        disp(6'd63, 0, 0, 1, 0, 0, 1, 0); step();
        chk("t4_full_hold", 64'(count), DEPTH);
        disp_valid = 1'b0;
        fu_ready = 3'b001;
        for (int j = 0; j < 6; j++) begin
            step();
            chk("t4_fu0_valid", 64'(iss_valid), 3'b001);
            chk("t4_fu0_rob", 64'(iss_rob[0 +: ROB_W]), 3 * j);
        end
        chk("t4_count_mid", 64'(count), 10);
        step();
        chk("t4_fu0_done", 64'(iss_valid), 0);
        fu_ready = 3'b111;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("t4_pair_valid", 64'(iss_valid), 3'b110);
            chk("t4_fu1_rob", 64'(iss_rob[1*ROB_W +: ROB_W]), 1 + 3 * j);
            chk("t4_fu2_rob", 64'(iss_rob[2*ROB_W +: ROB_W]), 2 + 3 * j);
        end
        chk("t4_drained", 64'(count), 0);

        // Older entry in a higher slot beats a younger one in slot 0
        fu_ready = 3'b010;
        disp(6'd40, 0, 6'd7, 0, 0, 0, 1, 0); step();
        disp(6'd41, 0, 6'd8, 0, 0, 0, 1, 0); step();
        chk("t5_count2", 64'(count), 2);
        disp_valid = 1'b0;
        wake(0, 6'd7, 32'hA7); step();
        wk_valid = '0; step();
        chk("t5_iss_p", 64'(iss_valid), 3'b010);
        chk("t5_rob_p", 64'(iss_rob[1*ROB_W +: ROB_W]), 40);
        disp(6'd42, 0, 6'd9, 0, 0, 0, 1, 0); step();
        disp_valid = 1'b0;
        chk("t5_count_r", 64'(count), 2);
        wake(0, 6'd8, 32'hA8);
        wake(1, 6'd9, 32'hA9);
        step();
        wk_valid = '0; step();
        chk("t5_iss_old", 64'(iss_valid), 3'b010);
        chk("t5_rob_old", 64'(iss_rob[1*ROB_W +: ROB_W]), 41);
        step();
        chk("t5_rob_young", 64'(iss_rob[1*ROB_W +: ROB_W]), 42);
        chk("t5_rs1_young", 64'(iss_rs1_val[1*DATA_W +: DATA_W]), 32'hA9);
        chk("t5_count0", 64'(count), 0);

        // Flush beats pending issue and a same-cycle dispatch
        fu_ready = 3'b000;
        for (int k = 0; k < 5; k++) begin
            disp(6'(50 + k), 0, 0, 1, 0, 0, 1, 0);
            step();
        end
        chk("t6_count5", 64'(count), 5);
        fu_ready = 3'b111;
        flush = 1'b1;
        disp(6'd60, 0, 0, 1, 0, 0, 1, 0);
        step();
        flush = 1'b0; disp_valid = 1'b0;
        chk("t6_flush_count", 64'(count), 0);
        chk("t6_flush_iss", 64'(iss_valid), 0);
        chk("t6_flush_rob", 64'(iss_rob), 0);
        step();
        chk("t6_after_iss", 64'(iss_valid), 0);
        chk("t6_after_count", 64'(count), 0);
        chk("t6_after_empty", 64'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
